// File: rtl/win_pkg.sv
// Shared Winograd F(2x2,3x3) definitions: default widths, row unpacking and
// the A-transpose coefficients used by the transform stages.
package win_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;

  // A-transpose of F(2x2,3x3): row 0 = {1,1,1,0}, row 1 = {0,1,-1,-1}
  localparam int AT [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

  // Element n (1..4) of a packed row {e1,e2,e3,e4}, e1 in the MSBs.
  function automatic logic [DW-1:0] elem(input logic [4*DW-1:0] row, input int unsigned n);
    return row[(4-n)*DW +: DW];
  endfunction

endpackage

// File: rtl/win_mac_at_if.sv
// Beat input and result output handshake of the Winograd MAC/output-transform stage.
interface win_mac_at_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            first;
  logic            last;
  logic [4*DW-1:0] v_tmp1, v_tmp2, v_tmp3, v_tmp4;
  logic [4*DW-1:0] u_tmp1, u_tmp2, u_tmp3, u_tmp4;
  logic            out_valid;
  logic            out_ready;
  logic [4*AW-1:0] y;

  modport master (
    output in_valid, first, last, v_tmp1, v_tmp2, v_tmp3, v_tmp4,
           u_tmp1, u_tmp2, u_tmp3, u_tmp4, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, first, last, v_tmp1, v_tmp2, v_tmp3, v_tmp4,
           u_tmp1, u_tmp2, u_tmp3, u_tmp4, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/win_at22.sv
// Combinational Winograd output transform Y = AT * M * A, 4x4 in, 2x2 out,
// all arithmetic AW-bit wrapping.
module win_at22 #(
  parameter int unsigned AW = 32
) (
  input  logic signed [AW-1:0] a [4][4],
  output logic signed [AW-1:0] y [2][2]
);
  import win_pkg::*;

  function automatic logic signed [AW-1:0] term(input int c, input logic signed [AW-1:0] x);
    if (c == 1)  return x;
    if (c == -1) return -x;
    return '0;
  endfunction

  // Coefficients are in {-1,0,1}, so each term folds to an add, subtract or nothing.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        y[i][k] = '0;
        for (int unsigned j = 0; j < 4; j++)
          for (int unsigned l = 0; l < 4; l++)
            y[i][k] = y[i][k] + term(AT[i][j] * AT[k][l], a[j][l]);
      end
    end
  end

endmodule

// File: rtl/win_mac_at.sv
// Winograd element-wise MAC over input channels followed by the 2x2 output
// transform; two-stage pipeline with a registered valid/ready output.
module win_mac_at #(
  parameter int unsigned DW = win_pkg::DW,
  parameter int unsigned AW = win_pkg::AW
) (
  input  logic         clk,
  input  logic         rst,
  win_mac_at_if.slave  bus
);
  import win_pkg::*;

  logic                 adv;
  logic                 p_valid, p_first, p_last;
  logic [4*DW-1:0]      v_row [4];
  logic [4*DW-1:0]      u_row [4];
  logic signed [AW-1:0] prod     [4][4];
  logic signed [AW-1:0] m        [4][4];
  logic signed [AW-1:0] acc      [4][4];
  logic signed [AW-1:0] acc_next [4][4];
  logic signed [AW-1:0] ty       [2][2];

  // A held result blocks the whole pipe; in_ready follows out_ready combinationally.
  assign adv          = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = adv;

  assign v_row = '{bus.v_tmp1, bus.v_tmp2, bus.v_tmp3, bus.v_tmp4};
  assign u_row = '{bus.u_tmp1, bus.u_tmp2, bus.u_tmp3, bus.u_tmp4};

  always_comb begin
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        prod[r][c] = AW'(signed'(v_row[r][(3-c)*DW +: DW])) *
                     AW'(signed'(u_row[r][(3-c)*DW +: DW]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      m       <= '{default: '0};
    end else if (adv) begin
      p_valid <= bus.in_valid;
      if (bus.in_valid) begin
        m       <= prod;
        p_first <= bus.first;
        p_last  <= bus.last;
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        acc_next[r][c] = p_first ? m[r][c] : acc[r][c] + m[r][c];
  end

  always_ff @(posedge clk) begin
    if (rst)
      acc <= '{default: '0};
    else if (p_valid && adv)
      acc <= acc_next;
  end

  win_at22 #(.AW(AW)) u_at22 (
    .a (acc_next),
    .y (ty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.y         <= '0;
    end else if (p_valid && adv && p_last) begin
      bus.out_valid <= 1'b1;
      bus.y         <= {ty[0][0], ty[0][1], ty[1][0], ty[1][1]};
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
